// File: rtl/vvalu_chain_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vvalu_chain_scheduler
// Purpose  : Replays each accepted vector once per configured chain toward
//            the vector-vector ALU, tagging every copy with its chain id.
// Options  : VVALU_SCHED_STATS_EN adds stat_accepted / stat_stalls counters.
// Revision : 1.0 - initial release
// ============================================================================
module vvalu_chain_scheduler #(
    parameter int N                  = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int MAX_CHAINS         = 4,
    parameter int PERSONAL_CONFIG_ID = 0,
    localparam int CW                = $clog2(MAX_CHAINS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             tracing,
    input  logic [7:0]                       configId,
    input  logic [7:0]                       configData,
    input  logic                             valid_in,
    input  logic                             eof_in,
    input  logic [N-1:0][DATA_WIDTH-1:0]     vector_in,
    output logic                             ready_out,
    output logic                             valid_out,
    output logic                             eof_out,
    output logic [CW-1:0]                    chainId_out,
`ifdef VVALU_SCHED_STATS_EN
    output logic [31:0]                      stat_accepted,
    output logic [31:0]                      stat_stalls,
`endif
    output logic [N-1:0][DATA_WIDTH-1:0]     vector_out
);

    localparam int CNW = $clog2(MAX_CHAINS + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    logic [0:0]                      state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [CNW-1:0]                  num_chains_q, num_chains_d;
    logic [CNW-1:0]                  cur_chains_q, cur_chains_d;
    logic                            valid_q, valid_d;
    logic                            eof_q, eof_d;
    logic [N-1:0][DATA_WIDTH-1:0]    vector_q, vector_d;

    logic                            last_issue;
    logic                            xfer;

    always_comb begin
        last_issue = (CNW'(cnt_q) == (cur_chains_q - CNW'(1)));
        if (state_q == S_ISSUE) begin
            ready_out = tracing & last_issue & ~rst;
        end else begin
            ready_out = tracing & ~rst;
        end
        xfer = valid_in & ready_out;
    end

    // Config writes land in num_chains only; cur_chains is latched per vector
    always_comb begin
        num_chains_d = num_chains_q;
        if (configId == 8'(PERSONAL_CONFIG_ID)) begin
            if (configData == 8'd0) begin
                num_chains_d = CNW'(1);
            end else if (configData > 8'(MAX_CHAINS)) begin
                num_chains_d = CNW'(MAX_CHAINS);
            end else begin
                num_chains_d = configData[CNW-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_chains_d = cur_chains_q;
        eof_d        = eof_q;
        vector_d     = vector_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!tracing) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (last_issue) begin
                    cnt_d = '0;
                    if (!xfer) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (xfer) begin
            cnt_d        = '0;
            cur_chains_d = num_chains_q;
            eof_d        = eof_in;
            vector_d     = vector_in;
        end
        valid_d = (state_d == S_ISSUE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            num_chains_q <= CNW'(1);
            cur_chains_q <= CNW'(1);
            valid_q      <= 1'b0;
            eof_q        <= 1'b0;
            vector_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            num_chains_q <= num_chains_d;
            cur_chains_q <= cur_chains_d;
            valid_q      <= valid_d;
            eof_q        <= eof_d;
            vector_q     <= vector_d;
        end
    end

    assign valid_out   = valid_q;
    assign eof_out     = eof_q;
    assign chainId_out = cnt_q;
    assign vector_out  = vector_q;

`ifdef VVALU_SCHED_STATS_EN
    logic [31:0] stat_accepted_q, stat_accepted_d;
    logic [31:0] stat_stalls_q, stat_stalls_d;

    always_comb begin
        stat_accepted_d = stat_accepted_q + (xfer ? 32'd1 : 32'd0);
        stat_stalls_d   = stat_stalls_q + ((valid_in & tracing & ~ready_out) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_accepted_q <= '0;
            stat_stalls_q   <= '0;
        end else begin
            stat_accepted_q <= stat_accepted_d;
            stat_stalls_q   <= stat_stalls_d;
        end
    end

    assign stat_accepted = stat_accepted_q;
    assign stat_stalls   = stat_stalls_q;
`endif

endmodule
`default_nettype wire
